// File: rtl/gcd_arbiter.sv
// rtl/gcd_arbiter.sv - two-port round-robin arbiter and sequencer for a shared GCD datapath
module gcd_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       vld0,
  output logic       vld1,
  output logic [3:0] res,
  output logic       err,
  output logic       gcd_start,
  output logic [3:0] gcd_a,
  output logic [3:0] gcd_b,
  input  logic       gcd_done,
  input  logic [3:0] gcd_res,
  output logic       busy,
  output logic       owner
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            lp_q, lp_d;
  logic            owner_q, owner_d;
  logic            gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic            vld0_q, vld0_d, vld1_q, vld1_d;
  logic [3:0]      res_q, res_d;
  logic            err_q, err_d;
  logic            start_q, start_d;
  logic [3:0]      opa_q, opa_d, opb_q, opb_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            win;
  logic [3:0]      win_a, win_b;

  // Round-robin winner: a tie goes to the requester not served last.
  always_comb begin
    win   = (req0 && req1) ? ~lp_q : req1;
    win_a = win ? a1 : a0;
    win_b = win ? b1 : b0;
  end

  // Next-state and registered-output logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    owner_d = owner_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    opa_d   = opa_q;
    opb_d   = opb_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = win;
          opa_d   = win_a;
          opb_d   = win_b;
          gnt0_d  = ~win;
          gnt1_d  = win;
          if (win_a == 4'd0 || win_b == 4'd0) begin
            // Trivial operands never reach the datapath: gcd(0,x) = x.
            res_d   = (win_a == 4'd0) ? win_b : win_a;
            err_d   = 1'b0;
            vld0_d  = ~win;
            vld1_d  = win;
            state_d = S_RESP;
          end else begin
            start_d = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (gcd_done) begin
          res_d   = gcd_res;
          err_d   = 1'b0;
          vld0_d  = ~owner_q;
          vld1_d  = owner_q;
          state_d = S_RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          res_d   = 4'd0;
          err_d   = 1'b1;
          vld0_d  = ~owner_q;
          vld1_d  = owner_q;
          state_d = S_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RESP: begin
        lp_d    = owner_q;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lp_q    <= 1'b1;
      owner_q <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      res_q   <= 4'd0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      opa_q   <= 4'd0;
      opb_q   <= 4'd0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      owner_q <= owner_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      res_q   <= res_d;
      err_q   <= err_d;
      start_q <= start_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      timer_q <= timer_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign vld0      = vld0_q;
  assign vld1      = vld1_q;
  assign res       = res_q;
  assign err       = err_q;
  assign gcd_start = start_q;
  assign gcd_a     = opa_q;
  assign gcd_b     = opb_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule
